// File: rtl/ad_param_measure.sv
// ad_param_measure: gated waveform measurement for the AD sample stream.
// Over each gate window it counts hysteresis-qualified rising edges and tracks
// the running max/min. At the end of the window it publishes edge count, max,
// min and peak-to-peak, then recentres the comparator threshold on the
// midpoint of the waveform just seen.
module ad_param_measure #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int HYST        = 8,
  parameter int FREQ_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ad_valid,
  input  logic [7:0]        ad_data,
  output logic [FREQ_W-1:0] ad_freq,
  output logic [7:0]        ad_max,
  output logic [7:0]        ad_min,
  output logic [7:0]        ad_vpp,
  output logic              meas_done
);

  localparam int               CNT_W     = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [8:0]       HYST9     = 9'(HYST);

  typedef enum logic {S_GATE, S_LATCH} state_t;

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    gate_cnt_q, gate_cnt_d;
  logic [FREQ_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [7:0]          run_max_q,  run_max_d;
  logic [7:0]          run_min_q,  run_min_d;
  logic                seen_q,     seen_d;
  logic [7:0]          thr_q,      thr_d;
  logic                cmp_hi_q,   cmp_hi_d;
  logic [FREQ_W-1:0]   freq_q,     freq_d;
  logic [7:0]          max_q,      max_d;
  logic [7:0]          min_q,      min_d;
  logic [7:0]          vpp_q,      vpp_d;
  logic                done_q,     done_d;

  logic [8:0]          hi_sum, hi_th, lo_th, thr_sum;
  logic                rise, fall;
  logic [7:0]          base_max, base_min;
  logic [FREQ_W-1:0]   base_edge;
  logic                base_seen;

  // Comparator thresholds around thr, saturated at the code range ends.
  always_comb begin
    hi_sum = {1'b0, thr_q} + HYST9;
    hi_th  = (hi_sum > 9'd255) ? 9'd255 : hi_sum;
    lo_th  = ({1'b0, thr_q} < HYST9) ? 9'd0 : ({1'b0, thr_q} - HYST9);
    rise   = ad_valid && !cmp_hi_q && ({1'b0, ad_data} >= hi_th);
    fall   = ad_valid &&  cmp_hi_q && ({1'b0, ad_data} <= lo_th);
  end

  // Next-state logic: gate sequencing, accumulators and result latching.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    thr_d      = thr_q;
    freq_d     = freq_q;
    max_d      = max_q;
    min_d      = min_q;
    vpp_d      = vpp_q;
    done_d     = 1'b0;
    cmp_hi_d   = rise ? 1'b1 : (fall ? 1'b0 : cmp_hi_q);
    thr_sum    = {1'b0, run_max_q} + {1'b0, run_min_q};

    // In S_LATCH the accumulators restart, so a sample arriving that cycle
    // is folded into cleared values and opens the next window.
    base_max  = (state_q == S_LATCH) ? 8'd0   : run_max_q;
    base_min  = (state_q == S_LATCH) ? 8'd255 : run_min_q;
    base_edge = (state_q == S_LATCH) ? '0     : edge_cnt_q;
    base_seen = (state_q == S_LATCH) ? 1'b0   : seen_q;

    run_max_d  = (ad_valid && ad_data > base_max) ? ad_data : base_max;
    run_min_d  = (ad_valid && ad_data < base_min) ? ad_data : base_min;
    seen_d     = base_seen | ad_valid;
    edge_cnt_d = (rise && base_edge != '1) ? base_edge + FREQ_W'(1) : base_edge;

    case (state_q)
      S_GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          gate_cnt_d = '0;
          state_d    = S_LATCH;
        end else begin
          gate_cnt_d = gate_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_GATE;
        done_d  = 1'b1;
        if (seen_q) begin
          freq_d = edge_cnt_q;
          max_d  = run_max_q;
          min_d  = run_min_q;
          vpp_d  = run_max_q - run_min_q;
          thr_d  = thr_sum[8:1];
        end else begin
          freq_d = '0;
          max_d  = 8'd0;
          min_d  = 8'd0;
          vpp_d  = 8'd0;
        end
      end
    endcase
  end

  // State and output registers; reset discards any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_GATE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      run_max_q  <= 8'd0;
      run_min_q  <= 8'd255;
      seen_q     <= 1'b0;
      thr_q      <= 8'd128;
      cmp_hi_q   <= 1'b0;
      freq_q     <= '0;
      max_q      <= 8'd0;
      min_q      <= 8'd0;
      vpp_q      <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      run_max_q  <= run_max_d;
      run_min_q  <= run_min_d;
      seen_q     <= seen_d;
      thr_q      <= thr_d;
      cmp_hi_q   <= cmp_hi_d;
      freq_q     <= freq_d;
      max_q      <= max_d;
      min_q      <= min_d;
      vpp_q      <= vpp_d;
      done_q     <= done_d;
    end
  end

  assign ad_freq   = freq_q;
  assign ad_max    = max_q;
  assign ad_min    = min_q;
  assign ad_vpp    = vpp_q;
  assign meas_done = done_q;

endmodule

// File: tb/tb_ad_param_measure.sv
// Scoreboard bench for ad_param_measure: the driver pushes hand-computed
// window results, the monitor pops one entry per meas_done pulse.
`timescale 1ns/1ps
module tb_ad_param_measure;

  localparam int GATE = 1000;

  localparam int K_IDLE = 0, K_NOISE = 1, K_SQUARE = 2, K_THR = 3, K_STEP = 4,
                 K_SMALL = 5, K_LOSAT = 6, K_PULSE = 7, K_CONST5 = 8, K_CONST40 = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        ad_valid;
  logic [7:0]  ad_data;
  logic [19:0] ad_freq;
  logic [7:0]  ad_max, ad_min, ad_vpp;
  logic        meas_done;
  logic [3:0]  ad_freq4;
  logic [7:0]  ad_max4, ad_min4, ad_vpp4;
  logic        meas_done4;

  ad_param_measure #(.GATE_CYCLES(GATE), .HYST(8), .FREQ_W(20)) dut (
    .clk(clk), .rst(rst), .ad_valid(ad_valid), .ad_data(ad_data),
    .ad_freq(ad_freq), .ad_max(ad_max), .ad_min(ad_min), .ad_vpp(ad_vpp),
    .meas_done(meas_done)
  );

  ad_param_measure #(.GATE_CYCLES(GATE), .HYST(8), .FREQ_W(4)) dut4 (
    .clk(clk), .rst(rst), .ad_valid(ad_valid), .ad_data(ad_data),
    .ad_freq(ad_freq4), .ad_max(ad_max4), .ad_min(ad_min4), .ad_vpp(ad_vpp4),
    .meas_done(meas_done4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cyc;
    int freq;
    int freq4;
    int mx;
    int mn;
    int vpp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(int id, int freq, int freq4, int mx, int mn, int vpp);
    exp_t e;
    e.id = id; e.cyc = 0; e.freq = freq; e.freq4 = freq4;
    e.mx = mx; e.mn = mn; e.vpp = vpp;
    return e;
  endfunction

  function automatic logic [7:0] pat(int kind, int i);
    case (kind)
      K_NOISE:   return 8'(123 + (i % 11));
      K_SQUARE:  return (i % 100 >= 50) ? 8'd200 : 8'd40;
      K_THR:     return (i % 100 >= 50) ? 8'd130 : 8'd110;
      K_STEP:    return (i < 500) ? 8'd255 : 8'd0;
      K_SMALL:   return (i % 100 >= 50) ? 8'd8 : 8'd0;
      K_LOSAT:   return (i % 100 >= 50) ? 8'd20 : ((i < 500) ? 8'd1 : 8'd0);
      K_PULSE:   return (i % 50 == 49) ? 8'd40 : 8'd0;
      K_CONST5:  return 8'd5;
      K_CONST40: return 8'd40;
      default:   return 8'd0;
    endcase
  endfunction

  // Monitor: pop and compare on each meas_done; between pulses track that
  // the published outputs stay frozen.
  logic [31:0] h_freq = 0, h_freq4 = 0, h_max = 0, h_min = 0, h_vpp = 0;
  bit          stable_ok = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      h_freq = 0; h_freq4 = 0; h_max = 0; h_min = 0; h_vpp = 0;
      stable_ok = 1'b1;
    end else if (meas_done || meas_done4) begin
      check("done_sync", 32'(meas_done4), 32'(meas_done));
      if (sb_q.size() == 0) begin
        check("unexpected_meas_done", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("w%0d_done_cycle", e.id), cyc,          e.cyc);
        check($sformatf("w%0d_stable",     e.id), 32'(stable_ok), 32'd1);
        check($sformatf("w%0d_freq",       e.id), 32'(ad_freq),  e.freq);
        check($sformatf("w%0d_max",        e.id), 32'(ad_max),   e.mx);
        check($sformatf("w%0d_min",        e.id), 32'(ad_min),   e.mn);
        check($sformatf("w%0d_vpp",        e.id), 32'(ad_vpp),   e.vpp);
        check($sformatf("w%0d_freq_w4",    e.id), 32'(ad_freq4), e.freq4);
        check($sformatf("w%0d_max_w4",     e.id), 32'(ad_max4),  e.mx);
        check($sformatf("w%0d_min_w4",     e.id), 32'(ad_min4),  e.mn);
        check($sformatf("w%0d_vpp_w4",     e.id), 32'(ad_vpp4),  e.vpp);
        h_freq = e.freq; h_freq4 = e.freq4; h_max = e.mx; h_min = e.mn; h_vpp = e.vpp;
        stable_ok = 1'b1;
      end
    end else begin
      if (32'(ad_freq) !== h_freq || 32'(ad_max) !== h_max || 32'(ad_min) !== h_min ||
          32'(ad_vpp) !== h_vpp || 32'(ad_freq4) !== h_freq4 || 32'(ad_max4) !== h_max ||
          32'(ad_min4) !== h_min || 32'(ad_vpp4) !== h_vpp)
        stable_ok = 1'b0;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_freq"},      32'(ad_freq),    32'd0);
    check({tag, "_max"},       32'(ad_max),     32'd0);
    check({tag, "_min"},       32'(ad_min),     32'd0);
    check({tag, "_vpp"},       32'(ad_vpp),     32'd0);
    check({tag, "_meas_done"}, 32'(meas_done),  32'd0);
    check({tag, "_freq_w4"},   32'(ad_freq4),   32'd0);
    check({tag, "_done_w4"},   32'(meas_done4), 32'd0);
  endtask

  // One window: GATE gate-cycle samples, then the S_LATCH-cycle sample.
  // A non-negative abort_at asserts reset at that gate slot instead.
  task automatic run_window(input int kind, input bit lat_v, input logic [7:0] lat_d,
                            input int abort_at, input exp_t e);
    e.cyc = cyc + GATE + 1;
    if (abort_at < 0) sb_q.push_back(e);
    for (int i = 0; i < GATE; i++) begin
      if (i == abort_at) begin
        ad_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs($sformatf("w%0d_midreset", e.id));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        return;
      end
      ad_valid = (kind != K_IDLE);
      ad_data  = pat(kind, i);
      @(negedge clk);
    end
    ad_valid = lat_v;
    ad_data  = lat_d;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    ad_valid = 1'b0;
    ad_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    run_window(K_NOISE,   1'b1, 8'd133, -1,  mk(1,  0,  0,  133, 123, 10));
    run_window(K_SQUARE,  1'b1, 8'd40,  -1,  mk(2,  10, 10, 200, 40,  160));
    run_window(K_SQUARE,  1'b0, 8'd0,   -1,  mk(3,  10, 10, 200, 40,  160));
    run_window(K_THR,     1'b0, 8'd0,   -1,  mk(4,  10, 10, 130, 110, 20));
    run_window(K_SQUARE,  1'b0, 8'd0,   500, mk(5,  0,  0,  0,   0,   0));
    run_window(K_IDLE,    1'b0, 8'd0,   -1,  mk(6,  0,  0,  0,   0,   0));
    run_window(K_STEP,    1'b1, 8'd0,   -1,  mk(7,  1,  1,  255, 0,   255));
    run_window(K_SMALL,   1'b1, 8'd0,   -1,  mk(8,  0,  0,  8,   0,   8));
    run_window(K_LOSAT,   1'b1, 8'd0,   -1,  mk(9,  6,  6,  20,  0,   20));
    run_window(K_PULSE,   1'b1, 8'd0,   -1,  mk(10, 20, 15, 40,  0,   40));
    run_window(K_CONST5,  1'b1, 8'd40,  -1,  mk(11, 0,  0,  5,   0,   5));
    run_window(K_CONST40, 1'b0, 8'd0,   -1,  mk(12, 1,  1,  40,  40,  0));

    ad_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
